rtclock_event_sched: RTL and testbench

//  Timed-event scheduler on top of the rtclock sec/nsec time base. N_REQ requesters each
//  arm one target time. The block shares a single 78-bit time comparator among them by

---
 rtl/rtclock_event_sched.sv | 138 +++++++++++++
 tb/tb_rtclock_event_sched.sv | 388 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rtclock_event_sched.sv
// rtclock_event_sched
// Timed-event scheduler for the rtclock sec/nsec time base. Each requester arms
// one target time. A single {sec,nsec} comparator is shared by scanning the slots
// round-robin, one slot per clock. A slot produces a one-cycle fire pulse when
// its target is reached. It produces a late pulse instead if the target had
// already passed when the slot was first evaluated. An arm request whose nsec is
// out of range is answered with a rej pulse.
module rtclock_event_sched #(
    parameter int N_REQ      = 4,
    parameter int SEC_WIDTH  = 48,
    parameter int NSEC_WIDTH = 30,
    parameter int NSEC_MAX   = 999999999
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [SEC_WIDTH-1:0]          sec,
    input  logic [NSEC_WIDTH-1:0]         nsec,
    input  logic [N_REQ-1:0]              req_valid,
    output logic [N_REQ-1:0]              req_ready,
    input  logic [N_REQ*SEC_WIDTH-1:0]    req_sec,
    input  logic [N_REQ*NSEC_WIDTH-1:0]   req_nsec,
    input  logic [N_REQ-1:0]              cancel,
    output logic [N_REQ-1:0]              armed,
    output logic [N_REQ-1:0]              fire,
    output logic [N_REQ-1:0]              late,
    output logic [N_REQ-1:0]              rej
);

    localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [NSEC_WIDTH-1:0] NSEC_LIMIT = NSEC_WIDTH'(NSEC_MAX);

    // Scan pointer: names the one slot that owns the comparator this cycle.
    logic [PTR_W-1:0]      ptr_reg;

    // Target storage. It is never reset; it is only meaningful while the slot is armed.
    logic [SEC_WIDTH-1:0]  tgt_sec_mem  [N_REQ];
    logic [NSEC_WIDTH-1:0] tgt_nsec_mem [N_REQ];

    logic [N_REQ-1:0]      accept;
    logic [N_REQ-1:0]      nsec_ok;
    logic [N_REQ-1:0]      eval_sel;
    logic [SEC_WIDTH-1:0]  cur_tgt_sec;
    logic [NSEC_WIDTH-1:0] cur_tgt_nsec;
    logic                  expired;

    // A slot can only be armed while it is idle and not being cancelled.
    // Reset also blocks new arms.
    assign req_ready = ~armed & ~cancel & {N_REQ{~rst}};

    // Scan pointer advances every clock whatever the slots hold, wrapping at N_REQ-1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg <= '0;
        end else if (ptr_reg == PTR_W'(N_REQ - 1)) begin
            ptr_reg <= '0;
        end else begin
            ptr_reg <= ptr_reg + PTR_W'(1);
        end
    end

    // Shared comparator: the selected slot's target against the live time.
    // Comparing the concatenation as one unsigned value gives sec-major ordering.
    always_comb begin
        cur_tgt_sec  = tgt_sec_mem[ptr_reg];
        cur_tgt_nsec = tgt_nsec_mem[ptr_reg];
        expired      = ({sec, nsec} >= {cur_tgt_sec, cur_tgt_nsec});
    end

    // Latch a target only when the arm is accepted and its nsec is legal.
    always_ff @(posedge clk) begin
        for (int i = 0; i < N_REQ; i++) begin
            if (accept[i] && nsec_ok[i]) begin
                tgt_sec_mem[i]  <= req_sec[i*SEC_WIDTH +: SEC_WIDTH];
                tgt_nsec_mem[i] <= req_nsec[i*NSEC_WIDTH +: NSEC_WIDTH];
            end
        end
    end

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slot
        logic                  armed_reg;
        logic                  fresh_reg;
        logic                  fire_reg;
        logic                  late_reg;
        logic                  rej_reg;
        logic [NSEC_WIDTH-1:0] slot_nsec;

        assign slot_nsec    = req_nsec[gi*NSEC_WIDTH +: NSEC_WIDTH];
        assign nsec_ok[gi]  = (slot_nsec <= NSEC_LIMIT);
        assign accept[gi]   = req_valid[gi] & req_ready[gi];
        assign eval_sel[gi] = (ptr_reg == PTR_W'(gi));

        // Per-slot state. Cancel wins over an expiry in the same cycle.
        // fresh marks a slot that has not been evaluated since arming, so that
        // a target already in the past is reported as late rather than fire.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                armed_reg <= 1'b0;
                fresh_reg <= 1'b0;
                fire_reg  <= 1'b0;
                late_reg  <= 1'b0;
                rej_reg   <= 1'b0;
            end else begin
                fire_reg <= 1'b0;
                late_reg <= 1'b0;
                rej_reg  <= 1'b0;
                if (cancel[gi]) begin
                    armed_reg <= 1'b0;
                    fresh_reg <= 1'b0;
                end else if (armed_reg) begin
                    if (eval_sel[gi]) begin
                        fresh_reg <= 1'b0;
                        if (expired) begin
                            armed_reg <= 1'b0;
                            if (fresh_reg) begin
                                late_reg <= 1'b1;
                            end else begin
                                fire_reg <= 1'b1;
                            end
                        end
                    end
                end else if (accept[gi]) begin
                    if (nsec_ok[gi]) begin
                        armed_reg <= 1'b1;
                        fresh_reg <= 1'b1;
                    end else begin
                        rej_reg <= 1'b1;
                    end
                end
            end
        end

        assign armed[gi] = armed_reg;
        assign fire[gi]  = fire_reg;
        assign late[gi]  = late_reg;
        assign rej[gi]   = rej_reg;
    end

endmodule

// File: tb/tb_rtclock_event_sched.sv
// Testbench for rtclock_event_sched: directed vector table, hand-written corner
// sequences and randomized traffic. Every cycle is checked against a
// behavioural model of the scheduler.
module tb_rtclock_event_sched;

    localparam int    N        = 4;
    localparam int    SW       = 48;
    localparam int    NW       = 30;
    localparam longint NS_PER_S = 1000000000;
    localparam int    K_FIRE = 0, K_LATE = 1, K_REJ = 2;

    logic            clk = 1'b0;
    logic            rst;
    logic [SW-1:0]   sec;
    logic [NW-1:0]   nsec;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*SW-1:0] req_sec;
    logic [N*NW-1:0] req_nsec;
    logic [N-1:0]    cancel;
    logic [N-1:0]    armed;
    logic [N-1:0]    fire;
    logic [N-1:0]    late;
    logic [N-1:0]    rej;

    rtclock_event_sched dut (
        .clk       (clk),
        .rst       (rst),
        .sec       (sec),
        .nsec      (nsec),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_sec   (req_sec),
        .req_nsec  (req_nsec),
        .cancel    (cancel),
        .armed     (armed),
        .fire      (fire),
        .late      (late),
        .rej       (rej)
    );

    always #4 clk = ~clk;

    // Model state: which slots hold a target, and whether each has been evaluated yet.
    bit   [N-1:0]  m_armed;
    bit   [N-1:0]  m_fresh;
    logic [SW-1:0] m_tsec  [N];
    logic [NW-1:0] m_tnsec [N];
    int            m_ptr;
    logic [N-1:0]  exp_fire, exp_late, exp_rej;

    bit            tick_en;
    logic [SW-1:0] edge_sec;
    logic [NW-1:0] edge_nsec;
    logic [N-1:0]  obs_fire, obs_late, obs_rej;
    int            n_checks = 0;
    int            n_fail   = 0;

    typedef struct {
        int            slot;
        logic [SW-1:0] a_sec;
        logic [NW-1:0] a_nsec;
        logic [SW-1:0] t_sec;
        logic [NW-1:0] t_nsec;
        int            kind;
        logic [SW-1:0] w_sec;
        logic [NW-1:0] w_lo;
        logic [NW-1:0] w_hi;
    } vec_t;

    vec_t tbl [8];

    function automatic bit reached(input logic [SW-1:0] s, input logic [NW-1:0] ns,
                                   input logic [SW-1:0] ts, input logic [NW-1:0] tns);
        return (s > ts) || ((s == ts) && (ns >= tns));
    endfunction

    task automatic check_vec(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, required %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
        n_checks++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    task automatic add_ns(inout logic [SW-1:0] s, inout logic [NW-1:0] ns, input longint d);
        longint v;
        v = longint'(ns) + d;
        while (v < 0) begin
            v += NS_PER_S;
            s = s - 1'b1;
        end
        while (v >= NS_PER_S) begin
            v -= NS_PER_S;
            s = s + 1'b1;
        end
        ns = NW'(v);
    endtask

    // Behaviour of one clock edge, in terms of the rules: the slot under the scan
    // pointer is judged (unless cancelled), then every slot handles cancel or arm.
    task automatic model_edge();
        bit [N-1:0]    was_armed;
        logic [NW-1:0] rn;
        int            s;
        exp_fire = '0;
        exp_late = '0;
        exp_rej  = '0;
        if (rst) begin
            m_armed = '0;
            m_fresh = '0;
            m_ptr   = 0;
            return;
        end
        was_armed = m_armed;
        s = m_ptr;
        if (was_armed[s] && !cancel[s]) begin
            if (reached(sec, nsec, m_tsec[s], m_tnsec[s])) begin
                if (m_fresh[s]) exp_late[s] = 1'b1;
                else            exp_fire[s] = 1'b1;
                m_armed[s] = 1'b0;
            end
            m_fresh[s] = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (cancel[i]) begin
                m_armed[i] = 1'b0;
                m_fresh[i] = 1'b0;
            end else if (!was_armed[i] && req_valid[i]) begin
                rn = req_nsec[i*NW +: NW];
                if (longint'(rn) < NS_PER_S) begin
                    m_armed[i] = 1'b1;
                    m_fresh[i] = 1'b1;
                    m_tsec[i]  = req_sec[i*SW +: SW];
                    m_tnsec[i] = rn;
                end else begin
                    exp_rej[i] = 1'b1;
                end
            end
        end
        m_ptr = (m_ptr + 1) % N;
    endtask

    // One clock: check the handshake, apply the edge, then check every output against the model.
    task automatic step();
        #1;
        check_vec("req_ready", req_ready, ~m_armed & ~cancel & {N{~rst}});
        model_edge();
        @(posedge clk);
        #1;
        edge_sec  = sec;
        edge_nsec = nsec;
        obs_fire  = fire;
        obs_late  = late;
        obs_rej   = rej;
        check_vec("armed", armed, m_armed);
        check_vec("fire", fire, exp_fire);
        check_vec("late", late, exp_late);
        check_vec("rej", rej, exp_rej);
        if (tick_en) add_ns(sec, nsec, 8);
    endtask

    task automatic set_req(input int slot, input logic [SW-1:0] s, input logic [NW-1:0] ns);
        req_valid[slot]        = 1'b1;
        req_sec[slot*SW +: SW] = s;
        req_nsec[slot*NW +: NW] = ns;
    endtask

    task automatic clear_inputs();
        req_valid = '0;
        cancel    = '0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int            n;
        int            kind_got;
        int            slot;
        bit            seen;
        int            fired [N];
        logic [SW-1:0] ts;
        logic [NW-1:0] tn;

        tbl[0] = '{2, 0, 400,       0, 2000,       K_FIRE, 0, 2000, 2024};
        tbl[1] = '{1, 0, 800,       0, 100,        K_LATE, 0, 0, 0};
        tbl[2] = '{0, 0, 0,         0, 1000000000, K_REJ,  0, 0, 0};
        tbl[3] = '{3, 0, 500,       0, 500,        K_LATE, 0, 0, 0};
        tbl[4] = '{0, 0, 999999000, 0, 999999999,  K_FIRE, 1, 0, 24};
        tbl[5] = '{3, 7, 100,       6, 999999999,  K_LATE, 0, 0, 0};
        tbl[6] = '{1, 2, 999999960, 3, 16,         K_FIRE, 3, 16, 40};
        tbl[7] = '{2, 0, 0,         0, 30'h3FFFFFFF, K_REJ, 0, 0, 0};

        rst       = 1'b1;
        sec       = '0;
        nsec      = '0;
        req_valid = '0;
        cancel    = '0;
        req_sec   = '0;
        req_nsec  = '0;
        tick_en   = 1'b0;
        m_armed   = '0;
        m_fresh   = '0;
        m_ptr     = 0;

        // Reset state.
        step();
        step();
        rst = 1'b0;
        step();

        // Table-driven single-slot scenarios: fire, late (including equality) and reject.
        for (int v = 0; v < 8; v++) begin
            slot = tbl[v].slot;
            cancel = '1;
            tick_en = 1'b0;
            step();
            clear_inputs();
            sec = tbl[v].a_sec;
            nsec = tbl[v].a_nsec;
            tick_en = 1'b1;
            set_req(slot, tbl[v].t_sec, tbl[v].t_nsec);
            step();
            req_valid = '0;
            seen = 1'b0;
            for (n = 0; n <= 260; n++) begin
                if (n > 0) step();
                if (obs_fire[slot] | obs_late[slot] | obs_rej[slot]) begin
                    seen = 1'b1;
                    break;
                end
            end
            check_int($sformatf("vec%0d pulse seen", v), seen, 1);
            if (seen) begin
                kind_got = obs_rej[slot] ? K_REJ : (obs_late[slot] ? K_LATE : K_FIRE);
                check_int($sformatf("vec%0d pulse kind", v), kind_got, tbl[v].kind);
                if (tbl[v].kind == K_REJ) begin
                    check_int($sformatf("vec%0d rej latency", v), n, 0);
                end else if (tbl[v].kind == K_LATE) begin
                    check_range($sformatf("vec%0d late latency", v), n, 1, N);
                end else begin
                    check_int($sformatf("vec%0d fire sec", v), edge_sec, tbl[v].w_sec);
                    check_range($sformatf("vec%0d fire nsec", v), edge_nsec, tbl[v].w_lo, tbl[v].w_hi);
                end
            end
            for (int k = 0; k < 6; k++) begin
                step();
                check_int($sformatf("vec%0d single pulse", v), obs_fire[slot] | obs_late[slot] | obs_rej[slot], 0);
            end
        end

        // Reset mid-run: armed slots are dropped at once and never pulse.
        tick_en = 1'b0;
        cancel = '1;
        step();
        clear_inputs();
        sec = 0;
        nsec = 0;
        for (int i = 0; i < 3; i++) set_req(i, 9, 0);
        step();
        req_valid = '0;
        step();
        step();
        sec = 20;
        rst = 1'b1;
        #1;
        check_vec("async reset armed", armed, '0);
        check_vec("async reset pulses", fire | late | rej, '0);
        step();
        step();
        rst = 1'b0;
        // Arm slot 0 with a past target on the first clock after reset: the scan
        // restarts at slot 0, so the late pulse needs a full lap of N clocks.
        set_req(0, 0, 0);
        step();
        req_valid = '0;
        seen = 1'b0;
        for (n = 1; n <= 2 * N; n++) begin
            step();
            if (obs_late[0]) begin
                seen = 1'b1;
                break;
            end
        end
        check_int("post-reset late seen", seen, 1);
        check_int("post-reset late latency", n, N);
        for (int k = 0; k < 8; k++) step();

        // Cancel racing the expiry of a non-fresh slot 3.
        cancel = '1;
        step();
        clear_inputs();
        sec = 0;
        nsec = 0;
        set_req(3, 5, 0);
        step();
        req_valid = '0;
        for (int k = 0; k < 5; k++) step();
        sec = 5;
        for (int k = 0; k < N && m_ptr != 3; k++) step();
        cancel[3] = 1'b1;
        step();
        check_int("cancel race fire", obs_fire[3], 0);
        check_int("cancel race armed", armed[3], 0);
        cancel = '0;
        for (int k = 0; k < 6; k++) begin
            step();
            check_int("cancel race no later fire", obs_fire[3] | obs_late[3], 0);
        end

        // Contention across the second boundary: every slot targets {1,0}.
        cancel = '1;
        step();
        clear_inputs();
        sec = 0;
        nsec = 999999904;
        tick_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            set_req(i, 1, 0);
            fired[i] = 0;
        end
        step();
        req_valid = '0;
        #1;
        check_vec("contention req_ready while armed", req_ready, '0);
        for (int k = 0; k < 40; k++) begin
            step();
            check_range("contention pulses per cycle", $countones(obs_fire | obs_late), 0, 1);
            check_int("contention no late", obs_late, 0);
            for (int i = 0; i < N; i++) begin
                if (obs_fire[i]) begin
                    fired[i]++;
                    check_int("contention fire sec", edge_sec, 1);
                    check_range("contention fire nsec", edge_nsec, 0, 24);
                end
            end
        end
        for (int i = 0; i < N; i++) check_int($sformatf("contention fires slot%0d", i), fired[i], 1);

        // Randomized traffic with occasional resets, cancels, bad targets and backward time steps.
        clear_inputs();
        sec = 10;
        nsec = 0;
        tick_en = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 399) == 0);
            for (int i = 0; i < N; i++) begin
                cancel[i]    = ($urandom_range(0, 39) == 0);
                req_valid[i] = ($urandom_range(0, 3) == 0);
                ts = sec;
                tn = nsec;
                add_ns(ts, tn, longint'($urandom_range(0, 600)) - 200);
                if ($urandom_range(0, 15) == 0) tn = NW'(1000000000 + $urandom_range(0, 50000000));
                req_sec[i*SW +: SW]  = ts;
                req_nsec[i*NW +: NW] = tn;
            end
            if ($urandom_range(0, 299) == 0) add_ns(sec, nsec, -300);
            step();
        end
        rst = 1'b0;
        clear_inputs();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
